receptor_sinc_4fases: RTL and testbench
=======================================

RECEPTOR_SINC_4FASES -- requirements
Module: receptor_sinc_4fases

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the FIFO depth in words; legal values are 2, 4 and 8.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on req_in; minimum 2.
REQ-003 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-004 Port clk, input, 1 bit, SHALL be the single rising-edge clock.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-006 Port req_in, input, 1 bit, SHALL be the four-phase request from the upstream asynchronous stage.
REQ-007 Port data_in, input, 8 bits, SHALL be the bundled data, stable from req_in rise until ack_out rise.
REQ-008 Port ack_out, output, 1 bit, SHALL be the four-phase acknowledge, registered and returned upstream as that stage's ack_next.
REQ-009 Port data_out, output, 8 bits, SHALL be the FIFO head word.
REQ-010 Port valid_out, output, 1 bit, SHALL be high when the FIFO holds at least one word.
REQ-011 Port ready_in, input, 1 bit, SHALL be the downstream accept.

Function
REQ-012 req_in SHALL pass through SYNC_STAGES flops; req_s is the last flop, and only req_s SHALL drive control.
REQ-013 data_in SHALL be sampled without synchronization, relying on the bundled-data stability rule in REQ-007.
REQ-014 The FSM SHALL have two states, ESPERA_REQ and ESPERA_BAIXO.
REQ-015 In ESPERA_REQ with req_s=1 and count<DEPTH, the FSM SHALL on that edge write data_in to the FIFO, set ack_out=1 and go to ESPERA_BAIXO.
REQ-016 In ESPERA_REQ with req_s=1 and count==DEPTH, the FSM SHALL hold, with ack_out=0 and no write, until count<DEPTH; a same-cycle pop SHALL NOT enable the write.
REQ-017 In ESPERA_BAIXO with req_s=0, the FSM SHALL set ack_out=0 and go to ESPERA_REQ; otherwise it SHALL hold with ack_out=1.
REQ-018 Latency from req_in rise to the ack_out rise SHALL be SYNC_STAGES+1 clock edges when not full.
REQ-019 Latency from req_in rise to valid_out rise SHALL be the same as REQ-018 when the FIFO was empty.
REQ-020 Exactly one FIFO write SHALL occur per four-phase cycle.
REQ-021 A pop SHALL occur on an edge with valid_out=1 and ready_in=1.
REQ-022 data_out SHALL then advance to the next word, or valid_out SHALL drop if the FIFO empties.
REQ-023 A simultaneous write and pop SHALL leave count unchanged and SHALL preserve ordering.
REQ-024 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-025 count SHALL be log2(DEPTH)+1 bits wide and SHALL never exceed DEPTH or underflow.
REQ-026 ready_in while valid_out=0 SHALL be ignored.
REQ-027 data_out SHALL be don't-care while valid_out=0.

Reset
REQ-028 When rst=1 at an edge, the block SHALL set ack_out=0, valid_out=0, count=0, both pointers to 0 and the FSM to ESPERA_BAIXO.
REQ-029 When rst=1 at an edge, the block SHALL set all synchronizer flops to 1.
REQ-030 A req_in held high across reset SHALL NOT be captured again; capture resumes only after req_s is seen low.
REQ-031 Reset mid-handshake SHALL discard the FIFO contents; upstream SHALL see ack_out fall and finish its return-to-zero phase.
REQ-032 The data_out value SHALL NOT be reset; the FIFO storage has no reset.

Structure
REQ-033 Package receptor_pkg SHALL hold the state enum (ESPERA_REQ, ESPERA_BAIXO), the constant LARGURA_DADO=8 and the DEPTH default.
REQ-034 Sub-module sincronizador_ff (parameter SYNC_STAGES, reset-to-1) SHALL implement the synchronizer.
REQ-035 The FIFO and FSM SHALL be inline in receptor_sinc_4fases.

Verification
REQ-036 After rst, with req_in=0, raising req_in with data_in=8'h56 and ready_in=0 SHALL give ack_out=1 and valid_out=1 with data_out=8'h56 three edges later.
REQ-037 Continuing from REQ-036, dropping req_in SHALL give ack_out=0 three edges later, with no second write (count stays 1).
REQ-038 Four handshakes 8'h01..8'h04 with ready_in=0 SHALL fill the FIFO; a fifth, 8'h05, SHALL keep ack_out=0.
REQ-039 Continuing from REQ-038, one pop SHALL make ack_out rise, and the pops SHALL then deliver 01,02,03,04,05 in order.
REQ-040 With count=2 and ready_in=1, a write landing on the same edge as a pop SHALL leave count=2, with data_out equal to the second word.
REQ-041 With req_in=1 and ack_out=1, pulsing rst SHALL give ack_out=0 and valid_out=0, and no capture until req_in falls and rises again.

Source files
------------

// File: rtl/receptor_pkg.sv
// ----------------------------------------------------------------------------
// receptor_pkg
//
// Shared declarations for the four-phase bundled-data receiver:
//   - estado_t            : handshake FSM states (ESPERA_REQ, ESPERA_BAIXO)
//   - LARGURA_DADO        : width of the bundled data word (8 bits)
//   - DEPTH_PADRAO        : default FIFO depth in words
//   - SYNC_STAGES_PADRAO  : default number of synchronizer flops on req_in
// ----------------------------------------------------------------------------
package receptor_pkg;

    // ESPERA_REQ   : idle, waiting for the synchronized request to rise.
    // ESPERA_BAIXO : word captured (or just out of reset), waiting for the
    //                synchronized request to return to zero.
    typedef enum logic {
        ESPERA_REQ   = 1'b0,
        ESPERA_BAIXO = 1'b1
    } estado_t;

    localparam int LARGURA_DADO       = 8;
    localparam int DEPTH_PADRAO       = 4;
    localparam int SYNC_STAGES_PADRAO = 2;

endpackage : receptor_pkg

// File: rtl/sincronizador_ff.sv
// ----------------------------------------------------------------------------
// sincronizador_ff
//
// Multi-flop synchronizer for a single asynchronous control bit.
//
// Ports:
//   clk  : rising-edge clock of the receiving domain
//   rst  : synchronous, active-high reset; forces every stage to 1
//   d    : asynchronous input bit
//   q    : synchronized output (last stage of the chain)
//
// Parameter:
//   SYNC_STAGES : number of flops in the chain (minimum 2)
//
// Every stage resets to 1 so that, straight after reset, the receiver sees the
// request as "still high" and cannot mistake a request held across reset for
// a fresh rising edge.
// ----------------------------------------------------------------------------
module sincronizador_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (SYNC_STAGES < 2) begin : g_estagios_invalidos
            $error("sincronizador_ff: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sinc_reg;

    // One flop per stage; stage 0 samples the raw asynchronous input, every
    // later stage samples its predecessor.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_estagio
            if (gi == 0) begin : g_primeiro
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sinc_reg[gi] <= 1'b1;
                    end else begin
                        sinc_reg[gi] <= d;
                    end
                end
            end else begin : g_seguinte
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sinc_reg[gi] <= 1'b1;
                    end else begin
                        sinc_reg[gi] <= sinc_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign q = sinc_reg[SYNC_STAGES-1];

endmodule : sincronizador_ff

// File: rtl/receptor_sinc_4fases.sv
// ----------------------------------------------------------------------------
// receptor_sinc_4fases
//
// Receiver that bridges a four-phase (return-to-zero) bundled-data
// asynchronous stage into a synchronous valid/ready stream through a small
// first-word-fall-through FIFO.
//
// Ports:
//   clk        : single rising-edge clock
//   rst        : synchronous, active-high reset
//   req_in     : four-phase request from the upstream asynchronous stage
//   data_in    : bundled data, stable from req_in rise until ack_out rise
//   ack_out    : registered four-phase acknowledge returned upstream
//   data_out   : FIFO head word (meaningless while valid_out = 0)
//   valid_out  : FIFO holds at least one word
//   ready_in   : downstream accept; a pop happens when valid_out & ready_in
//
// Parameters:
//   DEPTH       : FIFO depth in words (2, 4 or 8)
//   SYNC_STAGES : synchronizer flops on req_in (minimum 2)
//
// Timing when the FIFO is not full: a req_in rise produces the write and the
// ack_out rise SYNC_STAGES+1 edges later; a req_in fall produces the ack_out
// fall SYNC_STAGES+1 edges later.
// ----------------------------------------------------------------------------
module receptor_sinc_4fases
    import receptor_pkg::*;
#(
    parameter int DEPTH       = DEPTH_PADRAO,
    parameter int SYNC_STAGES = SYNC_STAGES_PADRAO
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_in,
    input  logic [LARGURA_DADO-1:0] data_in,
    output logic                    ack_out,
    output logic [LARGURA_DADO-1:0] data_out,
    output logic                    valid_out,
    input  logic                    ready_in
);

    generate
        if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_depth_invalido
            $error("receptor_sinc_4fases: DEPTH must be 2, 4 or 8");
        end
    endgenerate

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Request synchronizer. Only req_s may steer control; data_in is taken
    // raw because it is guaranteed stable while the request is pending.
    // ------------------------------------------------------------------
    logic req_s;

    sincronizador_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sinc_req (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_s)
    );

    // ------------------------------------------------------------------
    // State and FIFO bookkeeping
    // ------------------------------------------------------------------
    estado_t            estado_reg, estado_next;
    logic               ack_reg, ack_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    // Storage has no reset: the contents are discarded logically by clearing
    // the pointers and count, which is all the outside world can observe.
    logic [LARGURA_DADO-1:0] mem [DEPTH];

    logic fifo_cheia;
    logic wr_en;
    logic rd_en;

    // "Full" is judged on the registered count only, so a pop on the same
    // edge never lets a pending request slip into a full FIFO.
    assign fifo_cheia = (count_reg == CNT_W'(DEPTH));

    // ready_in is ignored while the FIFO is empty.
    assign rd_en = (count_reg != '0) && ready_in;

    // ------------------------------------------------------------------
    // Handshake FSM, next-state / output logic.
    // ack_out holds its registered value unless a transition changes it.
    // Reset lands in ESPERA_BAIXO with ack low: a request still high from
    // before reset is treated as an unfinished handshake, so nothing is
    // captured until req_s has been seen low.
    // ------------------------------------------------------------------
    always_comb begin
        estado_next = estado_reg;
        ack_next    = ack_reg;
        wr_en       = 1'b0;

        case (estado_reg)
            ESPERA_REQ: begin
                if (req_s && !fifo_cheia) begin
                    wr_en       = 1'b1;
                    ack_next    = 1'b1;
                    estado_next = ESPERA_BAIXO;
                end
            end

            ESPERA_BAIXO: begin
                if (!req_s) begin
                    ack_next    = 1'b0;
                    estado_next = ESPERA_REQ;
                end
            end

            default: begin
                ack_next    = 1'b0;
                estado_next = ESPERA_BAIXO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and FIFO control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_reg <= ESPERA_BAIXO;
            ack_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            estado_reg <= estado_next;
            ack_reg    <= ack_next;

            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            // Simultaneous write and pop leaves the occupancy unchanged.
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage. The head word is read combinationally so data_out is
    // already valid on the same edge valid_out rises (first-word
    // fall-through); depth is tiny, so this maps to distributed memory.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    assign data_out  = mem[rd_ptr_reg];
    assign valid_out = (count_reg != '0);
    assign ack_out   = ack_reg;

endmodule : receptor_sinc_4fases

// File: tb/tb_receptor_sinc_4fases.sv
// ----------------------------------------------------------------------------
// tb_receptor_sinc_4fases
//
// Self-checking bench for receptor_sinc_4fases (DEPTH=4, SYNC_STAGES=2).
// Directed scenarios cover reset, handshake latency, FIFO full back-pressure,
// simultaneous write/pop and reset in the middle of a handshake. A randomized
// scenario runs a well-behaved four-phase producer against a random consumer
// and compares every pop and every head word with a queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_receptor_sinc_4fases;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in;
    logic [7:0] data_in;
    logic       ack_out;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;

    int vetores = 0;
    int erros   = 0;

    always #5 clk = ~clk;

    receptor_sinc_4fases #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full four-phase cycle as an upstream stage would run it; ok=0 when the
    // acknowledge never arrives (or never returns to zero) within the bound.
    task automatic handshake(input logic [7:0] d, output bit ok);
        int n;
        ok      = 1'b1;
        req_in  = 1'b1;
        data_in = d;
        n = 0;
        while (ack_out !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (ack_out !== 1'b1) begin
            ok     = 1'b0;
            req_in = 1'b0;
            return;
        end
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        if (ack_out !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        req_in   = 1'b0;
        ready_in = 1'b0;
        data_in  = 8'h00;
        step();
        step();
        vetores++;
        if (ack_out !== 1'b0) begin
            erros++;
            $display("FAIL reset_ack: got %b want 0", ack_out);
        end
        vetores++;
        if (valid_out !== 1'b0) begin
            erros++;
            $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        rst = 1'b0;
        // Let req_s fall so the FSM can leave ESPERA_BAIXO.
        repeat (4) step();
        vetores++;
        if (ack_out !== 1'b0 || valid_out !== 1'b0) begin
            erros++;
            $display("FAIL reset_idle: got ack=%b valid=%b want 0/0", ack_out, valid_out);
        end
    endtask

    task automatic test_latencia();
        req_in  = 1'b1;
        data_in = 8'h56;
        for (int e = 1; e <= SYNC + 1; e++) begin
            step();
            vetores++;
            if (ack_out !== (e == SYNC + 1) || valid_out !== (e == SYNC + 1)) begin
                erros++;
                $display("FAIL lat_subida edge %0d: got ack=%b valid=%b want %b", e, ack_out, valid_out, (e == SYNC + 1));
            end
        end
        vetores++;
        if (data_out !== 8'h56) begin
            erros++;
            $display("FAIL lat_dado: got %h want 56", data_out);
        end

        req_in = 1'b0;
        for (int e = 1; e <= SYNC + 1; e++) begin
            step();
            vetores++;
            if (ack_out !== (e < SYNC + 1)) begin
                erros++;
                $display("FAIL lat_descida edge %0d: got ack=%b want %b", e, ack_out, (e < SYNC + 1));
            end
        end

        repeat (3) step();
        // Exactly one word must be held: one pop empties the FIFO.
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        vetores++;
        if (valid_out !== 1'b0) begin
            erros++;
            $display("FAIL lat_uma_escrita: got valid=%b want 0 after one pop", valid_out);
        end
    endtask

    task automatic test_cheio();
        bit ok;
        int n;
        for (int i = 1; i <= DEPTH; i++) begin
            handshake(8'(i), ok);
            vetores++;
            if (!ok) begin
                erros++;
                $display("FAIL cheio_hs %0d: got no handshake want complete", i);
            end
        end
        vetores++;
        if (valid_out !== 1'b1 || data_out !== 8'h01) begin
            erros++;
            $display("FAIL cheio_cabeca: got valid=%b data=%h want 1/01", valid_out, data_out);
        end

        req_in  = 1'b1;
        data_in = 8'h05;
        for (int e = 1; e <= 8; e++) begin
            step();
            vetores++;
            if (ack_out !== 1'b0) begin
                erros++;
                $display("FAIL cheio_bloqueio edge %0d: got ack=%b want 0", e, ack_out);
            end
        end

        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        vetores++;
        if (ack_out !== 1'b0 || data_out !== 8'h02) begin
            erros++;
            $display("FAIL cheio_pop: got ack=%b data=%h want 0/02", ack_out, data_out);
        end
        step();
        vetores++;
        if (ack_out !== 1'b1) begin
            erros++;
            $display("FAIL cheio_libera: got ack=%b want 1", ack_out);
        end

        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        vetores++;
        if (ack_out !== 1'b0) begin
            erros++;
            $display("FAIL cheio_rtz: got ack=%b want 0", ack_out);
        end

        for (int i = 2; i <= 5; i++) begin
            vetores++;
            if (valid_out !== 1'b1 || data_out !== 8'(i)) begin
                erros++;
                $display("FAIL cheio_ordem %0d: got valid=%b data=%h want 1/%h", i, valid_out, data_out, 8'(i));
            end
            ready_in = 1'b1;
            step();
            ready_in = 1'b0;
        end
        vetores++;
        if (valid_out !== 1'b0) begin
            erros++;
            $display("FAIL cheio_vazio: got valid=%b want 0", valid_out);
        end
    endtask

    task automatic test_simultaneo();
        bit ok;
        int n;
        handshake(8'hAA, ok);
        vetores++;
        if (!ok) begin
            erros++;
            $display("FAIL simult_hs1: got no handshake want complete");
        end
        handshake(8'hBB, ok);
        vetores++;
        if (!ok) begin
            erros++;
            $display("FAIL simult_hs2: got no handshake want complete");
        end

        // Write lands SYNC+1 edges after req rises; align one pop with it.
        req_in  = 1'b1;
        data_in = 8'hCC;
        repeat (SYNC) step();
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        vetores++;
        if (ack_out !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'hBB) begin
            erros++;
            $display("FAIL simult_mesma_borda: got ack=%b valid=%b data=%h want 1/1/BB", ack_out, valid_out, data_out);
        end

        // Count must still be 2: BB then CC, then empty.
        ready_in = 1'b1;
        step();
        vetores++;
        if (valid_out !== 1'b1 || data_out !== 8'hCC) begin
            erros++;
            $display("FAIL simult_segundo: got valid=%b data=%h want 1/CC", valid_out, data_out);
        end
        step();
        ready_in = 1'b0;
        vetores++;
        if (valid_out !== 1'b0) begin
            erros++;
            $display("FAIL simult_contagem: got valid=%b want 0", valid_out);
        end

        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        vetores++;
        if (ack_out !== 1'b0) begin
            erros++;
            $display("FAIL simult_rtz: got ack=%b want 0", ack_out);
        end
    endtask

    task automatic test_reset_meio();
        bit ok;
        int n;
        req_in  = 1'b1;
        data_in = 8'h11;
        n = 0;
        while (ack_out !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        vetores++;
        if (ack_out !== 1'b1) begin
            erros++;
            $display("FAIL rmeio_ack: got ack=%b want 1", ack_out);
        end

        rst = 1'b1;
        step();
        rst = 1'b0;
        vetores++;
        if (ack_out !== 1'b0 || valid_out !== 1'b0) begin
            erros++;
            $display("FAIL rmeio_reset: got ack=%b valid=%b want 0/0", ack_out, valid_out);
        end

        for (int e = 1; e <= 8; e++) begin
            step();
            vetores++;
            if (ack_out !== 1'b0 || valid_out !== 1'b0) begin
                erros++;
                $display("FAIL rmeio_sem_captura edge %0d: got ack=%b valid=%b want 0/0", e, ack_out, valid_out);
            end
        end

        req_in = 1'b0;
        repeat (4) step();
        handshake(8'h22, ok);
        vetores++;
        if (!ok) begin
            erros++;
            $display("FAIL rmeio_hs: got no handshake want complete");
        end
        vetores++;
        if (valid_out !== 1'b1 || data_out !== 8'h22) begin
            erros++;
            $display("FAIL rmeio_dado: got valid=%b data=%h want 1/22", valid_out, data_out);
        end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
    endtask

    task automatic test_aleatorio();
        logic [7:0] modelo[$];
        logic [7:0] esp;
        logic       v_ant, r_ant;
        logic [7:0] d_ant;
        int fase     = 0;
        int folga    = 0;
        int enviados = 0;
        int ciclos   = 0;
        localparam int N = 40;

        while (!(enviados == N && fase == 0 && modelo.size() == 0)) begin
            if (ciclos > 5000) begin
                vetores++;
                erros++;
                $display("FAIL aleat_timeout: got %0d of %0d handshakes, %0d words left", enviados, N, modelo.size());
                break;
            end
            v_ant = valid_out;
            r_ant = ready_in;
            d_ant = data_out;
            step();
            ciclos++;

            if (v_ant && r_ant) begin
                vetores++;
                if (modelo.size() == 0) begin
                    erros++;
                    $display("FAIL aleat_pop_vazio: got pop of %h want no word", d_ant);
                end else begin
                    esp = modelo.pop_front();
                    if (d_ant !== esp) begin
                        erros++;
                        $display("FAIL aleat_pop: got %h want %h", d_ant, esp);
                    end
                end
            end

            case (fase)
                0: begin
                    if (enviados < N) begin
                        if (folga == 0) begin
                            data_in = 8'($urandom);
                            req_in  = 1'b1;
                            fase    = 1;
                        end else begin
                            folga--;
                        end
                    end
                end
                1: begin
                    if (ack_out === 1'b1) begin
                        modelo.push_back(data_in);
                        req_in = 1'b0;
                        fase   = 2;
                    end
                end
                default: begin
                    if (ack_out === 1'b0) begin
                        fase = 0;
                        enviados++;
                        folga = int'($urandom_range(0, 3));
                    end
                end
            endcase

            vetores++;
            if (modelo.size() > DEPTH || valid_out !== (modelo.size() != 0)) begin
                erros++;
                $display("FAIL aleat_valid: got %b want %0d words", valid_out, modelo.size());
            end
            if (modelo.size() != 0) begin
                vetores++;
                if (data_out !== modelo[0]) begin
                    erros++;
                    $display("FAIL aleat_cabeca: got %h want %h", data_out, modelo[0]);
                end
            end

            // Slow consumer early on so the FIFO fills, faster one later.
            ready_in = ($urandom_range(0, 3) < ((enviados < N / 2) ? 1 : 3));
        end
        ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latencia();
        test_cheio();
        test_simultaneo();
        test_reset_meio();
        test_aleatorio();
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule : tb_receptor_sinc_4fases
